// File: rtl/pe_pkg.sv
// Shared definitions for the quantised weight-stationary PE and the array generator that tiles it.
// The width-check macro lives here so every module that sizes an accumulator applies the same rule.
`ifndef PE_PKG_SV
`define PE_PKG_SV

`define PE_CHECK_WIDTHS(acc_w, data_w) \
  if ((acc_w) < 2 * (data_w) || (acc_w) > pe_pkg::ACC_W_LIMIT) begin : g_bad_widths \
    $error("pe: ACC_W must be >= 2*DATA_W and <= ACC_W_LIMIT"); \
  end

package pe_pkg;

  localparam int PIPE_MIN    = 0;
  localparam int PIPE_MAX    = 1;
  localparam int ACC_W_LIMIT = 128;

  typedef logic signed [ACC_W_LIMIT-1:0] acc_wide_t;

  // Saturation bounds of a signed acc_w-bit accumulator, sliced down by the caller.
  function automatic acc_wide_t acc_max(int acc_w);
    return (acc_wide_t'(1) <<< (acc_w - 1)) - acc_wide_t'(1);
  endfunction

  function automatic acc_wide_t acc_min(int acc_w);
    return -(acc_wide_t'(1) <<< (acc_w - 1));
  endfunction

endpackage

`endif

// File: rtl/pe_sat_add.sv
// Combinational signed ACC_W adder: one guard bit detects overflow, SAT selects clamp or wrap.
module pe_sat_add import pe_pkg::*; #(
  parameter int ACC_W = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] ACC_MAX_V = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN_V = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] wide;

  always_comb begin
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Guard bit disagreeing with the sign bit means the true sum left the ACC_W range.
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    sum  = wide[ACC_W-1:0];
    if (SAT && ovf) begin
      sum = wide[ACC_W] ? ACC_MIN_V : ACC_MAX_V;
    end
  end

endmodule

// File: rtl/systolic_pe_q.sv
// Integer weight-stationary PE: double-buffered weights on a N->S shift chain, valid-tagged
// activations W->E, optional multiplier stage, global stall, saturating accumulate with sticky ovf.
module systolic_pe_q import pe_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int PIPE   = 1,
  parameter bit SAT    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] act_in,
  input  logic                     act_valid_in,
  output logic signed [DATA_W-1:0] act_out,
  output logic                     act_valid_out,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [ACC_W-1:0]  psum_out,
  output logic                     psum_valid_out,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic                     w_shift,
  output logic signed [DATA_W-1:0] w_out,
  input  logic                     w_swap,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  `PE_CHECK_WIDTHS(ACC_W, DATA_W)

  if (PIPE < PIPE_MIN || PIPE > PIPE_MAX) begin : g_bad_pipe
    $error("systolic_pe_q: PIPE must be 0 or 1");
  end

  logic signed [DATA_W-1:0]   w_shadow;
  logic signed [DATA_W-1:0]   w_active;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    add_p;
  logic signed [ACC_W-1:0]    add_psum;
  logic                       add_valid;
  logic signed [ACC_W-1:0]    sum;
  logic                       sum_ovf;

  assign w_out = w_shadow;

  // Weight chain ignores en so columns can be reloaded while the datapath is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_shadow <= '0;
      w_active <= '0;
    end else begin
      // NOTE: non-blocking assignments make a same-cycle swap+shift copy the old shadow.
      if (w_shift) w_shadow <= w_in;
      if (w_swap)  w_active <= w_shadow;
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a value up front, so no path can infer a latch.
    prod = act_in * w_active;
    if (!act_valid_in) begin
      prod = '0;
    end
    prod_ext = ACC_W'(prod);
  end

  if (PIPE == 1) begin : g_pipe
    logic signed [ACC_W-1:0] p_q;
    logic signed [ACC_W-1:0] psum_q;
    logic                    valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_q     <= '0;
        psum_q  <= '0;
        valid_q <= 1'b0;
      end else if (en) begin
        p_q     <= prod_ext;
        psum_q  <= psum_in;
        valid_q <= act_valid_in;
      end
    end

    assign add_p     = p_q;
    assign add_psum  = psum_q;
    assign add_valid = valid_q;
  end else begin : g_comb
    assign add_p     = prod_ext;
    assign add_psum  = psum_in;
    assign add_valid = act_valid_in;
  end

  pe_sat_add #(
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_add (
    .a   (add_psum),
    .b   (add_p),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_out        <= '0;
      act_valid_out  <= 1'b0;
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      if (en) begin
        act_out        <= act_in;
        act_valid_out  <= act_valid_in;
        psum_out       <= sum;
        psum_valid_out <= add_valid;
      end
      // A new overflow outranks a simultaneous clear; bypass cycles add zero and never overflow.
      ovf <= (en && add_valid && sum_ovf) || (ovf && !ovf_clr);
    end
  end

endmodule

// File: tb/tb_systolic_pe_q.sv
// Bench for systolic_pe_q: two chained PIPE=1/SAT=1 PEs plus one PIPE=0/SAT=0 PE, directed
// scenarios with hand-derived constants and a randomized run against a queue-based reference model.
module tb_systolic_pe_q;

  localparam int     DW      = 8;
  localparam int     AW      = 32;
  localparam int     N       = 3;
  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic signed [DW-1:0] act_in;
  logic                 act_valid_in;
  logic signed [AW-1:0] psum_in;
  logic signed [DW-1:0] w_in;
  logic                 w_shift;
  logic                 w_swap;
  logic                 ovf_clr;

  logic signed [DW-1:0] act_o  [N];
  logic                 av_o   [N];
  logic signed [AW-1:0] psum_o [N];
  logic                 pv_o   [N];
  logic signed [DW-1:0] w_o    [N];
  logic                 ovf_o  [N];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u_a sits above u_b in one column; u_c is a stand-alone PIPE=0, wrapping PE.
  systolic_pe_q #(.DATA_W(DW), .ACC_W(AW), .PIPE(1), .SAT(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en), .act_in(act_in), .act_valid_in(act_valid_in),
    .act_out(act_o[0]), .act_valid_out(av_o[0]), .psum_in(psum_in), .psum_out(psum_o[0]),
    .psum_valid_out(pv_o[0]), .w_in(w_in), .w_shift(w_shift), .w_out(w_o[0]),
    .w_swap(w_swap), .ovf(ovf_o[0]), .ovf_clr(ovf_clr));

  systolic_pe_q #(.DATA_W(DW), .ACC_W(AW), .PIPE(1), .SAT(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en), .act_in(act_in), .act_valid_in(act_valid_in),
    .act_out(act_o[1]), .act_valid_out(av_o[1]), .psum_in(psum_in), .psum_out(psum_o[1]),
    .psum_valid_out(pv_o[1]), .w_in(w_o[0]), .w_shift(w_shift), .w_out(w_o[1]),
    .w_swap(w_swap), .ovf(ovf_o[1]), .ovf_clr(ovf_clr));

  systolic_pe_q #(.DATA_W(DW), .ACC_W(AW), .PIPE(0), .SAT(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .act_in(act_in), .act_valid_in(act_valid_in),
    .act_out(act_o[2]), .act_valid_out(av_o[2]), .psum_in(psum_in), .psum_out(psum_o[2]),
    .psum_valid_out(pv_o[2]), .w_in(w_in), .w_shift(w_shift), .w_out(w_o[2]),
    .w_swap(w_swap), .ovf(ovf_o[2]), .ovf_clr(ovf_clr));

  // Reference model: each result is computed in full precision at issue time and delayed
  // through a queue holding (latency-1) entries; stalls simply stop the queue.
  typedef struct {
    longint psum;
    bit     v;
    bit     ovf;
  } res_t;

  res_t   pq [N][$];
  longint m_psum [N];
  bit     m_pv   [N];
  bit     m_ovf  [N];
  int     m_sh   [N];
  int     m_aw   [N];
  int     m_act;
  bit     m_av;

  function automatic int lat(int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic bit sat_of(int k);
    return k != 2;
  endfunction

  task automatic model_reset();
    res_t bubble;
    bubble = '{psum: 0, v: 1'b0, ovf: 1'b0};
    m_act = 0;
    m_av  = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_psum[k] = 0;
      m_pv[k]   = 1'b0;
      m_ovf[k]  = 1'b0;
      m_sh[k]   = 0;
      m_aw[k]   = 0;
      pq[k].delete();
      for (int i = 1; i < lat(k); i++) pq[k].push_back(bubble);
    end
  endtask

  task automatic model_step();
    int     sh_old [N];
    longint p;
    longint s;
    res_t   r;
    sh_old = m_sh;
    for (int k = 0; k < N; k++) begin
      if (en) begin
        p     = act_valid_in ? longint'(act_in) * longint'(m_aw[k]) : 64'sd0;
        s     = longint'(psum_in) + p;
        r.v   = act_valid_in;
        r.ovf = act_valid_in && (s > ACC_MAX || s < ACC_MIN);
        if (!r.ovf)         r.psum = s;
        else if (sat_of(k)) r.psum = (s > 0) ? ACC_MAX : ACC_MIN;
        else                r.psum = longint'(int'(s));
        pq[k].push_back(r);
        r         = pq[k].pop_front();
        m_psum[k] = r.psum;
        m_pv[k]   = r.v;
        m_ovf[k]  = r.ovf || (m_ovf[k] && !ovf_clr);
      end else begin
        m_ovf[k] = m_ovf[k] && !ovf_clr;
      end
    end
    if (en) begin
      m_act = int'(act_in);
      m_av  = act_valid_in;
    end
    for (int k = 0; k < N; k++) begin
      if (w_swap)  m_aw[k] = sh_old[k];
      if (w_shift) m_sh[k] = (k == 1) ? sh_old[0] : int'(w_in);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (psum_o[k] !== '0) begin n_err++; $display("FAIL reset_psum[%0d]: got %0d want 0", k, psum_o[k]); end
      n_cmp++; if (pv_o[k] !== 1'b0) begin n_err++; $display("FAIL reset_pvalid[%0d]: got %b want 0", k, pv_o[k]); end
      n_cmp++; if (act_o[k] !== '0) begin n_err++; $display("FAIL reset_act[%0d]: got %0d want 0", k, act_o[k]); end
      n_cmp++; if (av_o[k] !== 1'b0) begin n_err++; $display("FAIL reset_avalid[%0d]: got %b want 0", k, av_o[k]); end
      n_cmp++; if (w_o[k] !== '0) begin n_err++; $display("FAIL reset_wout[%0d]: got %0d want 0", k, w_o[k]); end
      n_cmp++; if (ovf_o[k] !== 1'b0) begin n_err++; $display("FAIL reset_ovf[%0d]: got %b want 0", k, ovf_o[k]); end
    end
  endtask

  task automatic test_weight_load();
    w_in = 8'sd3; w_shift = 1'b1; tick();
    w_in = 8'sd5; tick();
    w_shift = 1'b0;
    n_cmp++; if (w_o[0] !== 8'sd5) begin n_err++; $display("FAIL wload_upper_shadow: got %0d want 5", w_o[0]); end
    n_cmp++; if (w_o[1] !== 8'sd3) begin n_err++; $display("FAIL wload_lower_shadow: got %0d want 3", w_o[1]); end
    n_cmp++; if (w_o[2] !== 8'sd5) begin n_err++; $display("FAIL wload_single_shadow: got %0d want 5", w_o[2]); end
    w_swap = 1'b1; act_in = 8'sd2; act_valid_in = 1'b1; psum_in = '0;
    tick();
    w_swap = 1'b0;
    n_cmp++; if (psum_o[2] !== 32'sd0 || pv_o[2] !== 1'b1) begin n_err++; $display("FAIL wswap_old_weight_p0: got %0d/%b want 0/1", psum_o[2], pv_o[2]); end
    tick();
    n_cmp++; if (psum_o[2] !== 32'sd10) begin n_err++; $display("FAIL wswap_new_weight_p0: got %0d want 10", psum_o[2]); end
    n_cmp++; if (psum_o[0] !== 32'sd0 || pv_o[0] !== 1'b1) begin n_err++; $display("FAIL wswap_old_weight_upper: got %0d/%b want 0/1", psum_o[0], pv_o[0]); end
    n_cmp++; if (psum_o[1] !== 32'sd0 || pv_o[1] !== 1'b1) begin n_err++; $display("FAIL wswap_old_weight_lower: got %0d/%b want 0/1", psum_o[1], pv_o[1]); end
    act_valid_in = 1'b0;
    tick();
    n_cmp++; if (psum_o[0] !== 32'sd10) begin n_err++; $display("FAIL wswap_upper_active5: got %0d want 10", psum_o[0]); end
    n_cmp++; if (psum_o[1] !== 32'sd6) begin n_err++; $display("FAIL wswap_lower_active3: got %0d want 6", psum_o[1]); end
  endtask

  task automatic test_mac_latency();
    act_in = '0; psum_in = '0;
    w_in = -8'sd4; w_shift = 1'b1; tick();
    w_shift = 1'b0; w_swap = 1'b1; tick();
    w_swap = 1'b0;
    act_in = 8'sd7; act_valid_in = 1'b1; psum_in = 32'sd100;
    tick();
    n_cmp++; if (act_o[0] !== 8'sd7 || av_o[0] !== 1'b1) begin n_err++; $display("FAIL mac_act_lat1: got %0d/%b want 7/1", act_o[0], av_o[0]); end
    n_cmp++; if (psum_o[2] !== 32'sd72 || pv_o[2] !== 1'b1) begin n_err++; $display("FAIL mac_pipe0_lat1: got %0d/%b want 72/1", psum_o[2], pv_o[2]); end
    n_cmp++; if (pv_o[0] !== 1'b0) begin n_err++; $display("FAIL mac_pipe1_early: got valid %b want 0", pv_o[0]); end
    act_in = '0; act_valid_in = 1'b0; psum_in = '0;
    tick();
    n_cmp++; if (psum_o[0] !== 32'sd72 || pv_o[0] !== 1'b1) begin n_err++; $display("FAIL mac_pipe1_lat2: got %0d/%b want 72/1", psum_o[0], pv_o[0]); end
    n_cmp++; if (psum_o[1] !== 32'sd135 || pv_o[1] !== 1'b1) begin n_err++; $display("FAIL mac_lower_w5: got %0d/%b want 135/1", psum_o[1], pv_o[1]); end
    n_cmp++; if (pv_o[2] !== 1'b0) begin n_err++; $display("FAIL mac_pipe0_drop: got valid %b want 0", pv_o[2]); end
  endtask

  task automatic test_saturation();
    w_in = 8'sd5; w_shift = 1'b1; tick();
    w_shift = 1'b0; w_swap = 1'b1; tick();
    w_swap = 1'b0;
    act_in = 8'sd5; act_valid_in = 1'b1; psum_in = 32'sd2147483638;
    tick();
    n_cmp++; if (psum_o[2] !== -32'sd2147483633) begin n_err++; $display("FAIL sat_wrap_psum: got %0d want -2147483633", psum_o[2]); end
    n_cmp++; if (ovf_o[2] !== 1'b1) begin n_err++; $display("FAIL sat_wrap_ovf: got %b want 1", ovf_o[2]); end
    act_valid_in = 1'b0; psum_in = '0;
    tick();
    n_cmp++; if (psum_o[0] !== 32'sd2147483647) begin n_err++; $display("FAIL sat_clamp_psum: got %0d want 2147483647", psum_o[0]); end
    n_cmp++; if (ovf_o[0] !== 1'b1) begin n_err++; $display("FAIL sat_clamp_ovf: got %b want 1", ovf_o[0]); end
    n_cmp++; if (psum_o[1] !== 32'sd2147483618 || ovf_o[1] !== 1'b0) begin n_err++; $display("FAIL sat_no_ovf_lower: got %0d/%b want 2147483618/0", psum_o[1], ovf_o[1]); end
  endtask

  task automatic test_bypass_stall();
    act_in = 8'sd9; act_valid_in = 1'b0; psum_in = 32'sd55;
    repeat (2) tick();
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (psum_o[k] !== 32'sd55 || pv_o[k] !== 1'b0) begin n_err++; $display("FAIL bypass_psum[%0d]: got %0d/%b want 55/0", k, psum_o[k], pv_o[k]); end
      n_cmp++; if (ovf_o[k] !== (k != 1)) begin n_err++; $display("FAIL bypass_ovf_hold[%0d]: got %b want %b", k, ovf_o[k], k != 1); end
    end
    en = 1'b0; w_shift = 1'b1; w_in = 8'sd11;
    for (int c = 0; c < 3; c++) begin
      act_in = 8'($urandom); act_valid_in = 1'b1; psum_in = 32'($urandom);
      tick();
      for (int k = 0; k < N; k++) begin
        n_cmp++; if (psum_o[k] !== 32'sd55 || pv_o[k] !== 1'b0) begin n_err++; $display("FAIL stall_psum[%0d] c%0d: got %0d/%b want 55/0", k, c, psum_o[k], pv_o[k]); end
        n_cmp++; if (act_o[k] !== 8'sd9 || av_o[k] !== 1'b0) begin n_err++; $display("FAIL stall_act[%0d] c%0d: got %0d/%b want 9/0", k, c, act_o[k], av_o[k]); end
      end
      n_cmp++; if (w_o[0] !== 8'sd11) begin n_err++; $display("FAIL stall_wshift c%0d: got %0d want 11", c, w_o[0]); end
    end
    en = 1'b1; w_shift = 1'b0; act_valid_in = 1'b0; psum_in = '0;
  endtask

  task automatic test_ovf_clr();
    act_in = 8'sd5; act_valid_in = 1'b1; psum_in = 32'sd2147483638; ovf_clr = 1'b1;
    tick();
    n_cmp++; if (ovf_o[2] !== 1'b1) begin n_err++; $display("FAIL ovfclr_set_wins_p0: got %b want 1", ovf_o[2]); end
    n_cmp++; if (ovf_o[0] !== 1'b0) begin n_err++; $display("FAIL ovfclr_alone_upper: got %b want 0", ovf_o[0]); end
    act_valid_in = 1'b0; psum_in = '0;
    tick();
    n_cmp++; if (ovf_o[2] !== 1'b0) begin n_err++; $display("FAIL ovfclr_alone_p0: got %b want 0", ovf_o[2]); end
    n_cmp++; if (ovf_o[0] !== 1'b1) begin n_err++; $display("FAIL ovfclr_set_wins_upper: got %b want 1", ovf_o[0]); end
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf_o[0] !== 1'b0) begin n_err++; $display("FAIL ovfclr_final_upper: got %b want 0", ovf_o[0]); end
  endtask

  task automatic test_async_reset();
    act_in = 8'sd5; act_valid_in = 1'b1; psum_in = 32'sd2147483638;
    repeat (2) tick();
    n_cmp++; if (ovf_o[0] !== 1'b1 || pv_o[0] !== 1'b1) begin n_err++; $display("FAIL arst_prefill: got ovf %b valid %b want 1/1", ovf_o[0], pv_o[0]); end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      n_cmp++; if (psum_o[k] !== '0 || pv_o[k] !== 1'b0) begin n_err++; $display("FAIL arst_psum[%0d]: got %0d/%b want 0/0", k, psum_o[k], pv_o[k]); end
      n_cmp++; if (act_o[k] !== '0 || av_o[k] !== 1'b0) begin n_err++; $display("FAIL arst_act[%0d]: got %0d/%b want 0/0", k, act_o[k], av_o[k]); end
      n_cmp++; if (ovf_o[k] !== 1'b0 || w_o[k] !== '0) begin n_err++; $display("FAIL arst_ovf_w[%0d]: got %b/%0d want 0/0", k, ovf_o[k], w_o[k]); end
    end
    #1 rst = 1'b0;
    act_in = 8'sd4; act_valid_in = 1'b1; psum_in = 32'sd123;
    tick();
    n_cmp++; if (psum_o[2] !== 32'sd123 || pv_o[2] !== 1'b1) begin n_err++; $display("FAIL arst_first_p0: got %0d/%b want 123/1", psum_o[2], pv_o[2]); end
    n_cmp++; if (psum_o[0] !== 32'sd0 || pv_o[0] !== 1'b0) begin n_err++; $display("FAIL arst_no_partial: got %0d/%b want 0/0", psum_o[0], pv_o[0]); end
    act_valid_in = 1'b0; psum_in = '0;
    tick();
    n_cmp++; if (psum_o[0] !== 32'sd123 || pv_o[0] !== 1'b1) begin n_err++; $display("FAIL arst_first_p1: got %0d/%b want 123/1", psum_o[0], pv_o[0]); end
  endtask

  task automatic test_random();
    int mode;
    for (int c = 0; c < 600; c++) begin
      en           = ($urandom_range(0, 7) != 0);
      act_in       = 8'($urandom);
      act_valid_in = ($urandom_range(0, 3) != 0);
      w_in         = 8'($urandom);
      w_shift      = ($urandom_range(0, 3) == 0);
      w_swap       = ($urandom_range(0, 7) == 0);
      ovf_clr      = ($urandom_range(0, 15) == 0);
      mode         = $urandom_range(0, 2);
      if (mode == 0)      psum_in = 32'($urandom);
      else if (mode == 1) psum_in = 32'sh7FFF_FFFF - 32'($urandom_range(0, 20000));
      else                psum_in = 32'sh8000_0000 + 32'($urandom_range(0, 20000));
      tick();
      for (int k = 0; k < N; k++) begin
        n_cmp++; if (longint'(psum_o[k]) !== m_psum[k]) begin n_err++; $display("FAIL rnd_psum[%0d] c%0d: got %0d want %0d", k, c, psum_o[k], m_psum[k]); end
        n_cmp++; if (pv_o[k] !== m_pv[k]) begin n_err++; $display("FAIL rnd_pvalid[%0d] c%0d: got %b want %b", k, c, pv_o[k], m_pv[k]); end
        n_cmp++; if (ovf_o[k] !== m_ovf[k]) begin n_err++; $display("FAIL rnd_ovf[%0d] c%0d: got %b want %b", k, c, ovf_o[k], m_ovf[k]); end
        n_cmp++; if (int'(w_o[k]) !== m_sh[k]) begin n_err++; $display("FAIL rnd_wout[%0d] c%0d: got %0d want %0d", k, c, w_o[k], m_sh[k]); end
        n_cmp++; if (int'(act_o[k]) !== m_act || av_o[k] !== m_av) begin n_err++; $display("FAIL rnd_act[%0d] c%0d: got %0d/%b want %0d/%b", k, c, act_o[k], av_o[k], m_act, m_av); end
      end
    end
    en = 1'b1; w_shift = 1'b0; w_swap = 1'b0; ovf_clr = 1'b0; act_valid_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; act_in = '0; act_valid_in = 1'b0; psum_in = '0;
    w_in = '0; w_shift = 1'b0; w_swap = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_weight_load();
    test_mac_latency();
    test_saturation();
    test_bypass_stall();
    test_ovf_clr();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/systolic_pe_q.md
Name: systolic_pe_q

Overview:
- Parametrised, integer-datapath successor to the fp32 weight-stationary processing element.
- Activations flow west->east and partial sums flow north->south. Weights stay resident.
- Adds the following over the fp32 element:
  - double-buffered weights, loaded through a north->south shift chain
  - valid-tagged data
  - optional multiplier pipeline stage
  - global stall
  - saturating accumulation with a sticky overflow flag
- Tiled by the array generator into an R x C grid. The array controller applies the input skew.

Parameters:
- DATA_W, 8, signed activation/weight width.
- ACC_W, 32, signed partial-sum width. Must be >= 2*DATA_W; elaboration-time error otherwise.
- PIPE, 1, multiplier register stages (0 or 1).
- SAT, 1, 1 = saturate the add to the signed ACC_W range, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  compute enable; 0 = stall all datapath registers
- act_in  in  DATA_W  signed activation from west
- act_valid_in  in  1  activation valid
- act_out  out  DATA_W  activation to east
- act_valid_out  out  1  valid to east
- psum_in  in  ACC_W  signed partial sum from north
- psum_out  out  ACC_W  partial sum to south
- psum_valid_out  out  1  psum_out carries a product contribution
- w_in  in  DATA_W  weight shift-chain input from north
- w_shift  in  1  shift the weight chain
- w_out  out  DATA_W  shadow weight to south (chain output)
- w_swap  in  1  copy shadow weight into active weight
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset: every register clears to 0 on rst rising edge, regardless of clk. This covers act_out, act_valid_out, psum_out, psum_valid_out, w_out, active weight, pipeline registers and ovf. Reset mid-operation discards in-flight data; there is no partial output afterwards.
- Weight chain (independent of en):
  - w_shift=1: shadow <= w_in. w_out is always the shadow register, so an N-deep column loads in N shift cycles, bottom PE's weight first.
  - w_swap=1: active <= shadow.
  - w_swap and w_shift in the same cycle: active takes the old shadow; shadow takes w_in.
  - Products issued in the swap cycle use the old active weight; the new weight applies from the next cycle.
- Activation path, en=1: act_out <= act_in, act_valid_out <= act_valid_in. Latency 1.
- Arithmetic:
  - Product p = act_in * active_weight, signed, 2*DATA_W bits, sign-extended to ACC_W.
  - If act_valid_in=0, p is forced to 0; psum_in then passes through unchanged and psum_valid_out=0.
  - Sum = psum_in + p, computed at ACC_W+1 bits.
  - SAT=1: positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
  - SAT=0: result is wrapped.
- Latency:
  - PIPE=0: psum_out/psum_valid_out register the sum one cycle after act_in/psum_in.
  - PIPE=1: p, psum_in and valid are registered together. The adder result is registered the next cycle, so latency is 2.
  - psum_in must be presented in the same cycle as its activation.
- Stall, en=0: all datapath and pipeline registers hold, including act_out, psum_out and the valids. The weight chain and ovf_clr still act.
- Overflow flag:
  - ovf sets when a valid add overflows the ACC_W range, in both SAT modes.
  - ovf is sticky until ovf_clr or rst.
  - ovf_clr in the same cycle as a new overflow: set wins.
  - Overflow on an invalid (bypass) cycle cannot occur.
- Extreme operands: -2^(DATA_W-1) * -2^(DATA_W-1) is representable because ACC_W >= 2*DATA_W; no special case.

Decomposition:
- Shared package pe_pkg:
  - localparams for the PIPE limits
  - ACC_MAX/ACC_MIN helpers as functions of ACC_W
  - the ACC_W >= 2*DATA_W check macro, reused by the array generator
- One sub-module, pe_sat_add: combinational ACC_W adder with SAT parameter. Outputs the result and an overflow bit. Instantiated once per PE.

Test Plan:
1. Weight load/swap: shift weights 3 then 5 through two chained PEs, then swap. Required: upper active=5, lower active=3. A product issued in the swap cycle uses the old weight of 0.
2. MAC latency (PIPE=1): weight=-4, act_in=7 valid, psum_in=100. Required: psum_out=72 with psum_valid_out=1 exactly 2 cycles later; act_out=7 after 1 cycle. With PIPE=0, the same result appears after 1 cycle.
3. Saturation: SAT=1, ACC_W=32, psum_in=2^31-10, act=5, weight=5. Required: psum_out=2147483647 and ovf=1. With SAT=0, psum_out=-2147483633 (0x8000000F) and ovf=1.
4. Invalid bypass and stall: act_valid_in=0, act=9, psum_in=55. Required: psum_out=55, psum_valid_out=0, ovf unchanged. Then hold en=0 for 3 cycles. Required: all outputs frozen; a weight shift during the stall still updates w_out.
5. ovf_clr vs new overflow in the same cycle: ovf stays 1. ovf_clr alone: ovf=0 next cycle.
6. Async reset mid-stream: pulse rst between clock edges while the pipeline is full. Required: all outputs 0 immediately. The first valid result after reset appears only after the full latency.
